aes_result_fifo: RTL and testbench



---
 rtl/aes_result_fifo_if.sv | 32 +++
 rtl/aes_result_fifo.sv | 127 ++++++++++++
 tb/tb_aes_result_fifo.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_result_fifo_if.sv
// aes_result_fifo_if: capture/read bus between the AES core, the result
// buffer and the Wishbone slave read path.
interface aes_result_fifo_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic          done_i;
  logic [127:0]  res_i;
  logic          rd_i;
  logic          clr_i;
  logic [31:0]   rd_data_o;
  logic          rd_valid_o;
  logic          empty_o;
  logic          full_o;
  logic [AW:0]   count_o;
  logic          ovf_o;
  logic          udf_o;
  logic          irq_o;

  // Producer side: core flags plus Wishbone read strobe/flush
  modport master (
    output done_i, res_i, rd_i, clr_i,
    input  rd_data_o, rd_valid_o, empty_o, full_o, count_o, ovf_o, udf_o, irq_o
  );

  // Buffer side
  modport slave (
    input  done_i, res_i, rd_i, clr_i,
    output rd_data_o, rd_valid_o, empty_o, full_o, count_o, ovf_o, udf_o, irq_o
  );
endinterface

// File: rtl/aes_result_fifo.sv
// aes_result_fifo: queues 128-bit AES results on the rising edge of the core
// done flag and serialises each one MSB-first as four 32-bit words.
// Optional feature macro: AES_RESFIFO_OVF_IRQ_EN (registered overflow irq).
module aes_result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input logic              wb_clk_i,
  input logic              wb_rst_i,
  aes_result_fifo_if.slave bus
);
  localparam int unsigned CW = AW + 1;

  logic [127:0]  mem [DEPTH];
  logic [AW-1:0] wp_q;
  logic [AW-1:0] rp_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    widx_q;
  logic          done_d_q;
  logic [31:0]   rd_data_q;
  logic          rd_valid_q;
  logic          empty_q;
  logic          full_q;
  logic          ovf_q;
  logic          udf_q;

  logic          push_c;
  logic          rd_ok_c;
  logic          final_pop_c;
  logic          push_ok_c;
  logic [CW-1:0] cnt_nxt_c;
  logic [127:0]  head_c;
  logic [31:0]   word_c;

  // Event decode; a full buffer still accepts a push when the head leaves this cycle
  always_comb begin
    push_c      = bus.done_i & ~done_d_q;
    rd_ok_c     = bus.rd_i & (cnt_q != '0);
    final_pop_c = rd_ok_c & (widx_q == 2'd3);
    push_ok_c   = push_c & (~full_q | final_pop_c);
    cnt_nxt_c   = cnt_q + CW'(push_ok_c) - CW'(final_pop_c);
  end

  // Head-entry word select, MSB word first
  always_comb begin
    word_c = '0;
    head_c = mem[rp_q];
    case (widx_q)
      2'd0: word_c = head_c[127:96];
      2'd1: word_c = head_c[95:64];
      2'd2: word_c = head_c[63:32];
      2'd3: word_c = head_c[31:0];
      default: word_c = '0;
    endcase
  end

  // Pointers, count, flags and read word; clr_i outranks push and read
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wp_q       <= '0;
      rp_q       <= '0;
      cnt_q      <= '0;
      widx_q     <= '0;
      done_d_q   <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      done_d_q <= bus.done_i;
      if (bus.clr_i) begin
        wp_q       <= '0;
        rp_q       <= '0;
        cnt_q      <= '0;
        widx_q     <= '0;
        rd_valid_q <= 1'b0;
        empty_q    <= 1'b1;
        full_q     <= 1'b0;
        ovf_q      <= 1'b0;
        udf_q      <= 1'b0;
      end else begin
        rd_valid_q <= rd_ok_c;
        if (rd_ok_c) begin
          rd_data_q <= word_c;
          widx_q    <= widx_q + 2'd1;
        end
        if (final_pop_c) rp_q <= rp_q + AW'(1);
        if (push_ok_c)   wp_q <= wp_q + AW'(1);
        if (push_c & ~push_ok_c)  ovf_q <= 1'b1;
        if (bus.rd_i & ~rd_ok_c)  udf_q <= 1'b1;
        cnt_q   <= cnt_nxt_c;
        empty_q <= (cnt_nxt_c == '0);
        full_q  <= (cnt_nxt_c == CW'(DEPTH));
      end
    end
  end

  // Result storage; contents are deliberately left unreset
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i && !bus.clr_i && push_ok_c) mem[wp_q] <= bus.res_i;
  end

`ifdef AES_RESFIFO_OVF_IRQ_EN
  logic irq_q;

  // Overflow interrupt trails the sticky flag by one cycle
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)        irq_q <= 1'b0;
    else if (bus.clr_i)  irq_q <= 1'b0;
    else                 irq_q <= ovf_q;
  end

  assign bus.irq_o = irq_q;
`else
  assign bus.irq_o = 1'b0;
`endif

  assign bus.rd_data_o  = rd_data_q;
  assign bus.rd_valid_o = rd_valid_q;
  assign bus.empty_o    = empty_q;
  assign bus.full_o     = full_q;
  assign bus.count_o    = cnt_q;
  assign bus.ovf_o      = ovf_q;
  assign bus.udf_o      = udf_q;
endmodule

// File: tb/tb_aes_result_fifo.sv
// tb_aes_result_fifo: directed vector table, hand-written corner sequences and
// a randomized run checked against a queue-based model of the result buffer.
module tb_aes_result_fifo;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst = 1'b1;

  aes_result_fifo_if #(.DEPTH(DEPTH)) bus ();

  aes_result_fifo #(.DEPTH(DEPTH)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a queue of whole results plus a word cursor
  logic [127:0] mq[$];
  int           m_widx;
  logic [31:0]  m_data;
  logic         m_valid, m_ovf, m_udf, m_irq, m_prev;

  typedef struct {
    logic         done;
    logic [127:0] res;
    logic         rd;
    logic         clr;
    logic         ev;
    logic [31:0]  edata;
    logic [AW:0]  ecnt;
    logic         eempty;
    logic         efull;
    logic         eovf;
    logic         eudf;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_widx = 0; m_data = '0; m_valid = 0;
    m_ovf = 0; m_udf = 0; m_irq = 0; m_prev = 0;
  endtask

  task automatic model_step(input logic d, input logic [127:0] r, input logic rd, input logic c);
    logic push;
    logic [127:0] tmp;
    push   = d & ~m_prev;
    m_prev = d;
    if (c) begin
      mq.delete();
      m_widx = 0; m_ovf = 0; m_udf = 0; m_valid = 0; m_irq = 0;
    end else begin
`ifdef AES_RESFIFO_OVF_IRQ_EN
      m_irq = m_ovf;
`endif
      m_valid = 0;
      if (rd) begin
        if (mq.size() > 0) begin
          tmp     = mq[0];
          m_data  = 32'(tmp >> (32 * (3 - m_widx)));
          m_valid = 1;
          m_widx++;
          if (m_widx == 4) begin
            void'(mq.pop_front());
            m_widx = 0;
          end
        end else begin
          m_udf = 1;
        end
      end
      if (push) begin
        if (mq.size() < DEPTH) mq.push_back(r);
        else m_ovf = 1;
      end
    end
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, " valid"}, 128'(bus.rd_valid_o), 128'(m_valid));
    chk({tag, " data"},  128'(bus.rd_data_o),  128'(m_data));
    chk({tag, " count"}, 128'(bus.count_o),    128'(mq.size()));
    chk({tag, " empty"}, 128'(bus.empty_o),    128'(mq.size() == 0));
    chk({tag, " full"},  128'(bus.full_o),     128'(mq.size() == DEPTH));
    chk({tag, " ovf"},   128'(bus.ovf_o),      128'(m_ovf));
    chk({tag, " udf"},   128'(bus.udf_o),      128'(m_udf));
    chk({tag, " irq"},   128'(bus.irq_o),      128'(m_irq));
  endtask

  // Apply one cycle of inputs, then advance the model past the same edge
  task automatic step(input logic d, input logic [127:0] r, input logic rd, input logic c);
    bus.done_i = d; bus.res_i = r; bus.rd_i = rd; bus.clr_i = c;
    @(posedge clk);
    #1;
    model_step(d, r, rd, c);
  endtask

  function automatic logic [127:0] rres(input int k);
    return {32'(k), $urandom, $urandom, $urandom};
  endfunction

  localparam logic [127:0] R1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] R2 = 128'hDEADBEEF_01234567_89ABCDEF_FEEDFACE;
  localparam logic [127:0] R3 = 128'h0BADF00D_CAFEBABE_11112222_33334444;

  logic [127:0] rv[5];
  logic [127:0] rn;
  logic         d_cur;

  initial begin
    // Directed vector table: single result round trip, underflow, clr, edge detect
    vt[0]  = '{1, R1, 0, 0, 0, 32'h0,        1, 0, 0, 0, 0};
    vt[1]  = '{0, 0,  1, 0, 1, 32'h00112233, 1, 0, 0, 0, 0};
    vt[2]  = '{0, 0,  1, 0, 1, 32'h44556677, 1, 0, 0, 0, 0};
    vt[3]  = '{0, 0,  1, 0, 1, 32'h8899AABB, 1, 0, 0, 0, 0};
    vt[4]  = '{0, 0,  1, 0, 1, 32'hCCDDEEFF, 0, 1, 0, 0, 0};
    vt[5]  = '{0, 0,  1, 0, 0, 32'hCCDDEEFF, 0, 1, 0, 0, 1};
    vt[6]  = '{0, 0,  0, 1, 0, 32'hCCDDEEFF, 0, 1, 0, 0, 0};
    vt[7]  = '{1, R2, 0, 0, 0, 32'hCCDDEEFF, 1, 0, 0, 0, 0};
    vt[8]  = '{1, R3, 0, 0, 0, 32'hCCDDEEFF, 1, 0, 0, 0, 0};
    vt[9]  = '{0, 0,  0, 0, 0, 32'hCCDDEEFF, 1, 0, 0, 0, 0};
    vt[10] = '{1, R3, 0, 0, 0, 32'hCCDDEEFF, 2, 0, 0, 0, 0};
    vt[11] = '{0, 0,  0, 1, 0, 32'hCCDDEEFF, 0, 1, 0, 0, 0};

    bus.done_i = 0; bus.res_i = '0; bus.rd_i = 0; bus.clr_i = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset data",  128'(bus.rd_data_o),  128'h0);
    chk("reset valid", 128'(bus.rd_valid_o), 128'h0);
    chk("reset empty", 128'(bus.empty_o),    128'h1);
    chk("reset full",  128'(bus.full_o),     128'h0);
    chk("reset count", 128'(bus.count_o),    128'h0);
    chk("reset ovf",   128'(bus.ovf_o),      128'h0);
    chk("reset udf",   128'(bus.udf_o),      128'h0);
    chk("reset irq",   128'(bus.irq_o),      128'h0);
    rst = 0;

    for (int i = 0; i < 12; i++) begin
      step(vt[i].done, vt[i].res, vt[i].rd, vt[i].clr);
      chk($sformatf("vec%0d valid", i), 128'(bus.rd_valid_o), 128'(vt[i].ev));
      chk($sformatf("vec%0d data", i),  128'(bus.rd_data_o),  128'(vt[i].edata));
      chk($sformatf("vec%0d count", i), 128'(bus.count_o),    128'(vt[i].ecnt));
      chk($sformatf("vec%0d empty", i), 128'(bus.empty_o),    128'(vt[i].eempty));
      chk($sformatf("vec%0d full", i),  128'(bus.full_o),     128'(vt[i].efull));
      chk($sformatf("vec%0d ovf", i),   128'(bus.ovf_o),      128'(vt[i].eovf));
      chk($sformatf("vec%0d udf", i),   128'(bus.udf_o),      128'(vt[i].eudf));
    end

    // Level-held done pushes once; a fresh rising edge is needed for the next
    for (int i = 0; i < 10; i++) step(1, R2, 0, 0);
    chk("hold count", 128'(bus.count_o), 128'h1);
    step(0, 0, 0, 0);
    step(1, R3, 0, 0);
    chk("rehit count", 128'(bus.count_o), 128'h2);
    cmp_model("hold");
    step(0, 0, 0, 1);

    // Five pushes into a 4-deep buffer: 5th dropped, 1-4 read back across wrap
    for (int i = 0; i < 5; i++) begin
      rv[i] = rres(i + 1);
      step(1, rv[i], 0, 0);
      step(0, 0, 0, 0);
    end
    chk("ovf5 full",  128'(bus.full_o),  128'h1);
    chk("ovf5 count", 128'(bus.count_o), 128'h4);
    chk("ovf5 ovf",   128'(bus.ovf_o),   128'h1);
    step(0, 0, 0, 0);
    cmp_model("ovf5 irq");
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 1, 0);
      cmp_model($sformatf("ovf5 rd%0d", i));
    end
    chk("ovf5 last word", 128'(bus.rd_data_o), 128'(rv[3][31:0]));
    step(0, 0, 0, 1);
    cmp_model("ovf5 clr");

    // Full buffer with push on the head's final word: slot reused, no overflow
    for (int i = 0; i < 4; i++) begin
      rv[i] = rres(i + 16);
      step(1, rv[i], 0, 0);
      step(0, 0, 0, 0);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    rn = rres(99);
    step(1, rn, 1, 0);
    chk("swap count", 128'(bus.count_o), 128'h4);
    chk("swap ovf",   128'(bus.ovf_o),   128'h0);
    chk("swap full",  128'(bus.full_o),  128'h1);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 1, 0);
      cmp_model($sformatf("swap rd%0d", i));
    end
    chk("swap last word", 128'(bus.rd_data_o), 128'(rn[31:0]));
    step(0, 0, 0, 1);

    // Async reset mid-result: queue drops immediately, restart from word 0
    step(1, rres(40), 0, 0);
    step(0, 0, 0, 0);
    step(1, rres(41), 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    #2;
    rst = 1;
    #1;
    chk("arst count", 128'(bus.count_o),    128'h0);
    chk("arst empty", 128'(bus.empty_o),    128'h1);
    chk("arst valid", 128'(bus.rd_valid_o), 128'h0);
    bus.rd_i = 0;
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    step(1, R2, 0, 0);
    step(0, 0, 1, 0);
    chk("arst word0", 128'(bus.rd_data_o), 128'h0000_0000_DEADBEEF);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0);
      cmp_model($sformatf("arst rd%0d", i));
    end

    // Randomized traffic against the model
    d_cur = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 1) == 0) d_cur = ~d_cur;
      step(d_cur, rres(1000 + i), ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 59) == 0));
      cmp_model($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
